osc_sequencer: RTL and testbench

- Schedules note commands onto one pulse oscillator: which frequency control word and duty word it gets, for how long, and when it is silenced.
- Commands arrive on a valid/ready port and are buffered in a small FIFO.
- A tick divider sets the time base, and each command is played for an exact number of ticks.
- Sits between the control/host logic and the oscillator: drives the oscillator's ctrl, duty and rst inputs.

---
 rtl/osc_seq_pkg.sv | 32 +++
 rtl/osc_seq_fifo.sv | 56 +++++
 rtl/osc_sequencer.sv | 150 +++++++++++++++
 tb/tb_osc_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/osc_seq_pkg.sv
// Shared types for the oscillator note sequencer.
// OSC_SEQUENCER_SWEEP_EN adds a per-command signed duty sweep field.
package osc_seq_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StPlay} state_e;

    localparam int unsigned WordW   = 32;
    localparam int unsigned MaxDurW = 32;
`ifdef OSC_SEQUENCER_SWEEP_EN
    localparam int unsigned SweepW = 32;
`else
    localparam int unsigned SweepW = 0;
`endif

    typedef struct packed {
        logic [WordW-1:0]   ctrl;
        logic [WordW-1:0]   duty;
        logic [MaxDurW-1:0] dur;
`ifdef OSC_SEQUENCER_SWEEP_EN
        logic [WordW-1:0]   sweep;
`endif
    } cmd_t;

    // FIFO entry width: ctrl, duty, duration and (optionally) sweep.
    function automatic int unsigned cmd_width(input int unsigned dur_w);
        return 2 * WordW + dur_w + SweepW;
    endfunction

    localparam int unsigned DurWDefault = 16;
    localparam int unsigned CmdWDefault = cmd_width(DurWDefault);

endpackage

// File: rtl/osc_seq_fifo.sv
// Synchronous command FIFO with registered occupancy count and flush.
module osc_seq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/osc_sequencer.sv
// Note sequencer: queues commands and plays each on a pulse oscillator for dur ticks.
// Define OSC_SEQUENCER_SWEEP_EN to add cmd_sweep_i, a per-tick signed duty increment.
module osc_sequencer
    import osc_seq_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TICK_DIV = 48000,
    parameter int unsigned DUR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [31:0]      cmd_ctrl_i,
    input  logic [31:0]      cmd_duty_i,
    input  logic [DUR_W-1:0] cmd_dur_i,
`ifdef OSC_SEQUENCER_SWEEP_EN
    input  logic [31:0]      cmd_sweep_i,
`endif
    output logic [31:0]      osc_ctrl_o,
    output logic [31:0]      osc_duty_o,
    output logic             osc_rst_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int unsigned CmdW  = cmd_width(DUR_W);
    localparam int unsigned TickW = $clog2(TICK_DIV);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    state_e           state_q;
    logic [TickW-1:0] tick_q;
    logic [DUR_W-1:0] remaining_q;
    logic [31:0]      osc_ctrl_q, osc_duty_q;
    logic             osc_rst_q;
`ifdef OSC_SEQUENCER_SWEEP_EN
    logic [31:0]      sweep_q;
`endif

    logic [CmdW-1:0]  fifo_wdata, fifo_rdata;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CntW-1:0]  fifo_count;
    cmd_t             head;
    logic             head_zero, tick_last, last_tick;

`ifdef OSC_SEQUENCER_SWEEP_EN
    assign fifo_wdata = {cmd_ctrl_i, cmd_duty_i, cmd_dur_i, cmd_sweep_i};
`else
    assign fifo_wdata = {cmd_ctrl_i, cmd_duty_i, cmd_dur_i};
`endif

    assign cmd_ready_o = !fifo_full && !flush_i;
    assign fifo_push   = cmd_valid_i && cmd_ready_o;
    assign fifo_pop    = (state_q == StLoad);

    osc_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CmdW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        head                = '0;
        head.ctrl           = fifo_rdata[CmdW-1 -: 32];
        head.duty           = fifo_rdata[CmdW-33 -: 32];
        head.dur[DUR_W-1:0] = fifo_rdata[SweepW +: DUR_W];
`ifdef OSC_SEQUENCER_SWEEP_EN
        head.sweep          = fifo_rdata[31:0];
`endif
    end

    assign head_zero = (head.dur == '0);
    assign tick_last = (tick_q == TickW'(TICK_DIV - 1));
    assign last_tick = tick_last && (remaining_q == DUR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            remaining_q <= '0;
            osc_ctrl_q  <= '0;
            osc_duty_q  <= '0;
            osc_rst_q   <= 1'b1;
`ifdef OSC_SEQUENCER_SWEEP_EN
            sweep_q     <= '0;
`endif
        end else if (flush_i) begin
            state_q   <= StIdle;
            osc_rst_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    osc_rst_q <= 1'b1;
                    if (!fifo_empty) state_q <= StLoad;
                end
                StLoad: begin
                    tick_q      <= '0;
                    remaining_q <= head.dur[DUR_W-1:0];
                    if (head_zero) begin
                        // Zero-length note retires without touching the oscillator.
                        osc_rst_q <= 1'b1;
                        state_q   <= (fifo_count > CntW'(1)) ? StLoad : StIdle;
                    end else begin
                        osc_ctrl_q <= head.ctrl;
                        osc_duty_q <= head.duty;
`ifdef OSC_SEQUENCER_SWEEP_EN
                        sweep_q    <= head.sweep;
`endif
                        osc_rst_q  <= 1'b0;
                        state_q    <= StPlay;
                    end
                end
                StPlay: begin
                    if (tick_last) begin
                        tick_q      <= '0;
                        remaining_q <= remaining_q - DUR_W'(1);
`ifdef OSC_SEQUENCER_SWEEP_EN
                        osc_duty_q  <= osc_duty_q + sweep_q;
`endif
                        if (last_tick) begin
                            osc_rst_q <= 1'b1;
                            state_q   <= fifo_empty ? StIdle : StLoad;
                        end
                    end else begin
                        tick_q <= tick_q + TickW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign osc_ctrl_o = osc_ctrl_q;
    assign osc_duty_o = osc_duty_q;
    assign osc_rst_o  = osc_rst_q;
    assign busy_o     = (state_q != StIdle) || !fifo_empty;
    assign done_o     = !rst && !flush_i &&
                        (((state_q == StLoad) && head_zero) || ((state_q == StPlay) && last_tick));

endmodule

// File: tb/tb_osc_sequencer.sv
// Bench for osc_sequencer: directed scenarios plus random traffic against a note-level model.
module tb_osc_sequencer;
    localparam int unsigned TD = 4;
    localparam int unsigned DP = 4;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst, flush, cmd_valid;
    logic [31:0]   cmd_ctrl, cmd_duty, cmd_sweep;
    logic [DW-1:0] cmd_dur;
    logic          cmd_ready, osc_rst, busy, done;
    logic [31:0]   osc_ctrl, osc_duty;

    always #5 clk = ~clk;

    osc_sequencer #(
        .DEPTH    (DP),
        .TICK_DIV (TD),
        .DUR_W    (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_ctrl_i  (cmd_ctrl),
        .cmd_duty_i  (cmd_duty),
        .cmd_dur_i   (cmd_dur),
`ifdef OSC_SEQUENCER_SWEEP_EN
        .cmd_sweep_i (cmd_sweep),
`endif
        .osc_ctrl_o  (osc_ctrl),
        .osc_duty_o  (osc_duty),
        .osc_rst_o   (osc_rst),
        .busy_o      (busy),
        .done_o      (done)
    );

    // Note-level model: a queue of commands, and the note being played described by
    // how many play cycles are left and how many have elapsed.
    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] duty;
        logic [31:0] sweep;
        int unsigned dur;
    } mcmd_t;

    mcmd_t       mq[$];
    int          m_mode;  // 0 idle, 1 load, 2 play
    int unsigned m_left, m_played;
    logic [31:0] m_ctrl, m_base, m_sweep;

    int n_checks = 0;
    int n_errors = 0;
    int n_done, n_quiet;
    bit last_push;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode   = 0;
        m_left   = 0;
        m_played = 0;
        m_ctrl   = '0;
        m_base   = '0;
        m_sweep  = '0;
    endtask

    task automatic cycle(input logic r, input logic f, input logic v, input logic [31:0] c,
                         input logic [31:0] d, input logic [DW-1:0] du, input logic [31:0] sw);
        logic [31:0] ticks, exp_duty;
        logic        exp_done;
        bit          do_push;
        mcmd_t       hc;
        @(negedge clk);
        rst = r; flush = f; cmd_valid = v;
        cmd_ctrl = c; cmd_duty = d; cmd_dur = du; cmd_sweep = sw;
        #1;
        ticks    = 32'(m_played / TD);
        exp_duty = m_base + m_sweep * ticks;
        exp_done = !r && !f && ((m_mode == 1 && mq.size() > 0 && mq[0].dur == 0) ||
                                (m_mode == 2 && m_left == 1));
        check_eq("osc_rst", 64'(osc_rst), 64'(m_mode != 2));
        check_eq("osc_ctrl", 64'(osc_ctrl), 64'(m_ctrl));
        check_eq("osc_duty", 64'(osc_duty), 64'(exp_duty));
        check_eq("busy", 64'(busy), 64'(m_mode != 0 || mq.size() != 0));
        check_eq("done", 64'(done), 64'(exp_done));
        check_eq("cmd_ready", 64'(cmd_ready), 64'(mq.size() < DP && !f));
        if (done) n_done++;
        if (!osc_rst) n_quiet++;

        last_push = 1'b0;
        if (r) begin
            model_reset();
        end else if (f) begin
            mq.delete();
            m_mode = 0;
        end else begin
            do_push = v && (mq.size() < DP);
            case (m_mode)
                0: if (mq.size() > 0) m_mode = 1;
                1: begin
                    hc = mq.pop_front();
                    if (hc.dur == 0) begin
                        m_mode = (mq.size() > 0) ? 1 : 0;
                    end else begin
                        m_ctrl   = hc.ctrl;
                        m_base   = hc.duty;
                        m_sweep  = hc.sweep;
                        m_played = 0;
                        m_left   = hc.dur * TD;
                        m_mode   = 2;
                    end
                end
                default: begin
                    m_played++;
                    m_left--;
                    if (m_left == 0) m_mode = (mq.size() > 0) ? 1 : 0;
                end
            endcase
            if (do_push) begin
                hc.ctrl = c;
                hc.duty = d;
`ifdef OSC_SEQUENCER_SWEEP_EN
                hc.sweep = sw;
`else
                hc.sweep = '0;
`endif
                hc.dur  = int'(du);
                mq.push_back(hc);
            end
            last_push = do_push;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    // Holds the command on the port until accepted, within a bounded number of cycles.
    task automatic push_cmd(input logic [31:0] c, input logic [31:0] d, input logic [DW-1:0] du,
                            input logic [31:0] sw);
        int k = 0;
        do begin
            cycle(1'b0, 1'b0, 1'b1, c, d, du, sw);
            k++;
        end while (!last_push && k < 60);
        if (!last_push) check_eq("push_timeout", 64'(k), 64'(0));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0;
        cmd_ctrl = '0; cmd_duty = '0; cmd_dur = '0; cmd_sweep = '0;
        repeat (2) @(posedge clk);
        model_reset();
        cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);

        // Idle after reset.
        n_done = 0;
        idle(20);
        check_eq("idle_done_cnt", 64'(n_done), 64'(0));
        check_eq("idle_ready", 64'(cmd_ready), 64'(1));

        // Single note, dur=3: exactly 12 sounding cycles and one done.
        n_done = 0; n_quiet = 0;
        push_cmd(32'h1000_0000, 32'h8000_0000, 16'd3, '0);
        idle(20);
        check_eq("single_quiet_cnt", 64'(n_quiet), 64'(12));
        check_eq("single_done_cnt", 64'(n_done), 64'(1));
        check_eq("single_ctrl_hold", 64'(osc_ctrl), 64'h1000_0000);

        // Five back-to-back notes of dur=2.
        n_done = 0; n_quiet = 0;
        for (int i = 0; i < 5; i++) push_cmd(32'h100 * (i + 1), 32'h4000_0000, 16'd2, '0);
        idle(60);
        check_eq("b2b_done_cnt", 64'(n_done), 64'(5));
        check_eq("b2b_quiet_cnt", 64'(n_quiet), 64'(40));

        // Zero-length note followed by a one-tick note.
        n_done = 0; n_quiet = 0;
        push_cmd(32'hDEAD_0000, 32'h1, 16'd0, '0);
        push_cmd(32'h0BEE_F000, 32'h2, 16'd1, '0);
        idle(15);
        check_eq("zero_done_cnt", 64'(n_done), 64'(2));
        check_eq("zero_quiet_cnt", 64'(n_quiet), 64'(4));

        // Flush in the middle of a long note with two queued.
        n_done = 0;
        push_cmd(32'h2222_0000, 32'h3, 16'd10, '0);
        push_cmd(32'h3333_0000, 32'h4, 16'd2, '0);
        push_cmd(32'h4444_0000, 32'h5, 16'd2, '0);
        idle(8);
        cycle(1'b0, 1'b1, 1'b1, 32'h5555_0000, '0, 16'd1, '0);
        idle(3);
        check_eq("flush_busy", 64'(busy), 64'(0));
        check_eq("flush_osc_rst", 64'(osc_rst), 64'(1));
        check_eq("flush_done_cnt", 64'(n_done), 64'(0));

        // Reset in the middle of a long note.
        push_cmd(32'h6666_0000, 32'h6, 16'd10, '0);
        push_cmd(32'h7777_0000, 32'h7, 16'd2, '0);
        idle(8);
        cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        idle(3);
        check_eq("rst_ctrl", 64'(osc_ctrl), 64'(0));
        check_eq("rst_duty", 64'(osc_duty), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done_cnt", 64'(n_done), 64'(0));

`ifdef OSC_SEQUENCER_SWEEP_EN
        // Duty sweep wraps modulo 2^32.
        push_cmd(32'h0100_0000, 32'hFFFF_FFF0, 16'd2, 32'h20);
        idle(15);
        check_eq("sweep_final_duty", 64'(osc_duty), 64'h30);
`endif

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            cycle(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 99) == 0),
                  1'($urandom_range(0, 1)), $urandom, $urandom,
                  DW'($urandom_range(0, 3)), $urandom);
        end
        idle(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
